// File: rtl/nyakuo_pkg.sv
// Shared nyakuo core types: instruction enum, register addresses, memory bus constants
// and the load/store helper functions used by the LSU.
package nyakuo_pkg;

  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    NOP, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  } instruction;

  typedef logic [4:0] reg_addr;
  localparam reg_addr ZERO = 5'd0;

  // mem_we encoding shared with the data-memory bus
  localparam logic READ = 1'b0;
  localparam logic LOAD = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

  function automatic logic is_mem_op(input instruction op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  function automatic logic is_load(input instruction op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic mem_size_t op_size(input instruction op);
    case (op)
      LB, LBU, SB: return BYTE;
      LH, LHU, SH: return HALF;
      default:     return WORD;
    endcase
  endfunction

endpackage

// File: rtl/nyakuo_lsu_align.sv
// Byte-lane steering for the LSU: enables, store replication, misalign detect, load extension.
// Purely combinational; no state, no backpressure.
module nyakuo_lsu_align
  import nyakuo_pkg::*;
(
  input  instruction        op,
  input  logic [1:0]        lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [3:0]        be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic              misalign,
  output logic [XLEN-1:0]   rdata_ext
);

  mem_size_t   size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size      = op_size(op);
    be        = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    rdata_ext = rdata;
    byte_lane = rdata[{lo, 3'b000} +: 8];
    half_lane = rdata[{lo[1], 4'b0000} +: 16];
    if (is_mem_op(op)) begin
      case (size)
        BYTE: begin
          be        = 4'b0001 << lo;
          wdata_rep = {4{wdata[7:0]}};
          rdata_ext = (op == LB) ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
        end
        HALF: begin
          misalign  = lo[0];
          be        = lo[0] ? 4'b0000 : (4'b0011 << lo);
          wdata_rep = {2{wdata[15:0]}};
          rdata_ext = (op == LH) ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
        end
        WORD: begin
          misalign  = |lo;
          be        = (|lo) ? 4'b0000 : 4'hF;
        end
        default: be = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/nyakuo_lsu.sv
// Load/store unit: one memory op at a time, accept->wb_valid in 3 cycles minimum (+ gnt stall).
// req_ready only in IDLE; mem_req held with stable payload until mem_gnt.
module nyakuo_lsu
  import nyakuo_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  instruction        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  reg_addr           req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output reg_addr           wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic              busy
);

  lsu_state_t  state, state_nx;
  instruction  op_q;
  logic [1:0]  lo_q;
  reg_addr     rd_q;
  logic        accept;

  instruction        al_op;
  logic [1:0]        al_lo;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_mis;

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one for load extraction.
  nyakuo_lsu_align u_align (
    .op        (al_op),
    .lo        (al_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .misalign  (al_mis),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    al_op     = op_q;
    al_lo     = lo_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        al_op     = req_op;
        al_lo     = req_addr[1:0];
        if (req_valid && is_mem_op(req_op)) begin
          accept = 1'b1;
          if (!al_mis) state_nx = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nx = RESP;
      end
      RESP: begin
        if (mem_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= NOP;
      lo_q          <= 2'b00;
      rd_q          <= ZERO;
      mem_we        <= READ;
      mem_addr      <= '0;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= ZERO;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (accept) begin
        if (al_mis) begin
          misalign      <= 1'b1;
          misalign_addr <= req_addr;
        end else begin
          op_q      <= req_op;
          lo_q      <= req_addr[1:0];
          rd_q      <= req_rd;
          mem_we    <= is_load(req_op) ? READ : LOAD;
          mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          mem_be    <= al_be;
          mem_wdata <= al_wdata;
        end
      end
      if (state == RESP && mem_rvalid && is_load(op_q)) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= (rd_q == ZERO) ? '0 : al_rdata;
      end
    end
  end

endmodule

// File: tb/tb_nyakuo_lsu.sv
// Directed bench for nyakuo_lsu with a writeback scoreboard.
module tb_nyakuo_lsu;
  import nyakuo_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  instruction  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  reg_addr     req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  reg_addr     wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t wb_q[$];

  nyakuo_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .misalign_addr(misalign_addr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = wb_q.pop_front();
        check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        check("wb_data", wb_data, e.data);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input string tag, input instruction op, input logic [31:0] addr,
                       input logic [31:0] wdata, input reg_addr rd, input logic [31:0] rdata,
                       input int gdly, input logic ewe, input logic [3:0] ebe,
                       input logic [31:0] ewdata, input logic [31:0] edata);
    int acc;
    logic [31:0] eaddr;
    eaddr = addr & 32'hFFFF_FFFC;
    check({tag, "_ready_in"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    acc = cyc;
    req_valid = 1'b0; req_op = NOP;
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd1);
    check({tag, "_mem_addr"}, mem_addr, eaddr);
    check({tag, "_mem_be"}, {28'b0, mem_be}, {28'b0, ebe});
    check({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, ewe});
    if (ewe) check({tag, "_mem_wdata"}, mem_wdata, ewdata);
    check({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < gdly; i++) begin
      step();
      check({tag, "_stall_req"}, {31'b0, mem_req}, 32'd1);
      check({tag, "_stall_addr"}, mem_addr, eaddr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_busy_resp"}, {31'b0, busy}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata = rdata;
    if (!ewe) wb_q.push_back('{rd: rd, data: edata, cyc: acc + 2 + gdly});
    step();
    mem_rvalid = 1'b0;
    check({tag, "_ready_out"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy_out"}, {31'b0, busy}, 32'd0);
    if (ewe) check({tag, "_no_wb"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = NOP; req_addr = '0; req_wdata = '0; req_rd = ZERO;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step(); step();
    rst = 1'b0;
    step();
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    check("rst_mis_addr", misalign_addr, 32'd0);

    //     tag     op   addr          wdata         rd     rdata         gdly we  be       wdata         load result
    do_op("lw",   LW,  32'h100, 32'h0,        5'd1,  32'hDEADBEEF, 0, 1'b0, 4'hF,    32'h0,        32'hDEADBEEF);
    do_op("lb",   LB,  32'h103, 32'h0,        5'd2,  32'h80FF0000, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80);
    do_op("lbu",  LBU, 32'h103, 32'h0,        5'd3,  32'h80FF0000, 0, 1'b0, 4'b1000, 32'h0,        32'h00000080);
    do_op("sh",   SH,  32'h202, 32'h0000ABCD, 5'd0,  32'h0,        0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
    do_op("sb",   SB,  32'h001, 32'h12345678, 5'd0,  32'h0,        0, 1'b1, 4'b0010, 32'h78787878, 32'h0);
    do_op("sw",   SW,  32'h044, 32'hCAFEF00D, 5'd0,  32'h0,        0, 1'b1, 4'hF,    32'hCAFEF00D, 32'h0);
    do_op("lh",   LH,  32'h006, 32'h0,        5'd7,  32'h80011234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001);
    do_op("lhu",  LHU, 32'h006, 32'h0,        5'd8,  32'h80011234, 0, 1'b0, 4'b1100, 32'h0,        32'h00008001);
    do_op("lb1",  LB,  32'h011, 32'h0,        5'd9,  32'h00007F00, 0, 1'b0, 4'b0010, 32'h0,        32'h0000007F);
    do_op("lw_st",LW,  32'h180, 32'h0,        5'd10, 32'h01234567, 4, 1'b0, 4'hF,    32'h0,        32'h01234567);
    do_op("lh_x0",LH,  32'h000, 32'h0,        ZERO,  32'h00008001, 0, 1'b0, 4'b0011, 32'h0,        32'h0);

    // Misaligned word: trapped without any memory request.
    req_valid = 1'b1; req_op = LW; req_addr = 32'h101; req_rd = 5'd4;
    step();
    req_valid = 1'b0; req_op = NOP;
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_addr", misalign_addr, 32'h101);
    check("mis_no_req", {31'b0, mem_req}, 32'd0);
    check("mis_idle", {31'b0, busy}, 32'd0);
    step();
    check("mis_one_cycle", {31'b0, misalign}, 32'd0);
    check("mis_still_no_req", {31'b0, mem_req}, 32'd0);

    // Misaligned halfword.
    req_valid = 1'b1; req_op = LHU; req_addr = 32'h203;
    step();
    req_valid = 1'b0; req_op = NOP;
    check("mis_h_pulse", {31'b0, misalign}, 32'd1);
    check("mis_h_addr", misalign_addr, 32'h203);
    check("mis_h_no_req", {31'b0, mem_req}, 32'd0);

    // Non-memory op is ignored.
    req_valid = 1'b1; req_op = ADD; req_addr = 32'h3;
    step();
    req_valid = 1'b0; req_op = NOP;
    check("alu_ready", {31'b0, req_ready}, 32'd1);
    check("alu_no_req", {31'b0, mem_req}, 32'd0);
    check("alu_no_mis", {31'b0, misalign}, 32'd0);

    // Reset in RESP aborts the load; the late rvalid must not write back.
    req_valid = 1'b1; req_op = LW; req_addr = 32'h300; req_rd = 5'd5;
    step();
    req_valid = 1'b0; req_op = NOP;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_idle", {31'b0, busy}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_no_req", {31'b0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_rvalid = 1'b0;
    check("abort_no_wb", {31'b0, wb_valid}, 32'd0);
    step();
    check("abort_no_wb2", {31'b0, wb_valid}, 32'd0);

    step(); step();
    check("wb_pending", wb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nyakuo_lsu.md
Name: nyakuo_lsu

Overview:
Load/store unit of the nyakuo core; sits directly downstream of the decode/execute stage that classifies instructions with the shared instruction enum. Accepts one decoded LB/LH/LBU/LHU/LW/SB/SH/SW per handshake with a computed effective address. Drives a single-ported data-memory request/response bus. Returns sign- or zero-extended load data plus destination register for register-file writeback, and flags misaligned accesses.

Parameters:
ADDR_W, 32, effective/memory address width
DATA_W, 32, data width; fixed at 32 (RV32I)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept (high only in IDLE)
req_op  in  instruction  one of LB,LH,LBU,LHU,LW,SB,SH,SW
req_addr  in  ADDR_W  effective address (rs1+imm)
req_wdata  in  DATA_W  store data (rs2)
req_rd  in  reg_addr  load destination
mem_req  out  1  memory request valid
mem_we  out  1  READ(0)=load, LOAD(1)=write, using package constants
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_be  out  4  byte enables
mem_wdata  out  DATA_W  lane-replicated store data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data / write ack valid
mem_rdata  in  DATA_W  raw read word
wb_valid  out  1  one-cycle pulse, load result valid
wb_rd  out  reg_addr  writeback register
wb_data  out  DATA_W  extended load data
misalign  out  1  one-cycle pulse, misaligned access trapped
misalign_addr  out  ADDR_W  offending address
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; mem_req, wb_valid, misalign, busy = 0; mem_addr/mem_be/mem_wdata/wb_data/wb_rd/misalign_addr = 0. Reset mid-transaction aborts it; a later mem_rvalid is ignored while in IDLE.
- FSM IDLE -> REQ -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid, latch op/addr/wdata/rd.
  - Misaligned (H ops addr[0]!=0; W ops addr[1:0]!=0): no memory access; next cycle misalign=1, misalign_addr=addr; stay IDLE.
  - Otherwise go REQ.
- REQ: mem_req=1 with stable addr/we/be/wdata until mem_gnt. Sample gnt at clock edge -> RESP; mem_req drops the following cycle.
- RESP: wait mem_rvalid.
  - Load: register wb_valid=1 the next cycle with wb_rd and extracted data; return to IDLE.
  - Store: no wb_valid; return to IDLE.
  - rd==ZERO load: memory still accessed, wb_valid still pulsed, wb_data forced to 0.
- Min latency: accept at edge N, mem_req visible N+1, gnt same cycle, rvalid N+2, wb_valid N+3. Throughput one op per 3 cycles min; no outstanding >1.
- Byte enables: B = 1<<addr[1:0]; H = 2'b11<<addr[1:0]; W = 4'hF.
- Store data: B replicated to all 4 lanes; H replicated to both halves; W unchanged.
- Load extract: byte lane = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW raw.
- Non-memory op with req_valid: ignored, req_ready stays 1, no outputs.
- mem_rvalid in IDLE or REQ: ignored.

Decomposition:
- nyakuo_pkg gains: lsu_state_t enum (IDLE,REQ,RESP); mem_size_t (BYTE,HALF,WORD); function is_mem_op(instruction); function is_load(instruction).
- Existing READ/LOAD constants used for mem_we.
- One sub-module: nyakuo_lsu_align, combinational: op + addr[1:0] -> be, lane-replicated wdata, misalign flag, and rdata extraction/extension. FSM stays in nyakuo_lsu.

Test Plan:
- LW addr 0x100, rdata 0xDEADBEEF, gnt immediate, rvalid next -> mem_be=F, mem_addr=0x100, wb_valid 3 cycles after accept, wb_data=0xDEADBEEF.
- LB addr 0x103 rdata 0x80FF_0000 -> be=4'b1000, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202 wdata 0x0000ABCD -> mem_we=1, be=4'b1100, mem_wdata=0xABCDABCD, no wb_valid, req_ready high again after rvalid.
- LW addr 0x101 -> no mem_req; misalign=1 one cycle with misalign_addr=0x101.
- LW with gnt held low 4 cycles -> mem_req/addr stable 4 cycles, proceeds on gnt; rst asserted during RESP -> IDLE next cycle, late rvalid produces no wb_valid.
- LH addr 0x0 with rd=ZERO, rdata 0x0000_8001 -> wb_valid=1, wb_data=0.
